// File: rtl/csi_rx_dly_cal.sv
// Per-lane IDELAYE2 tap sweep/centre calibration for a CSI-2 HS data lane.
// Optional: CSI_RX_DLY_CAL_ROTATE_EN enables rotation-tolerant pattern match.
module csi_rx_dly_cal #(
  parameter logic [7:0] PATTERN     = 8'hB8,
  parameter int         SAMPLE_LEN  = 256,
  parameter int         SETTLE_CYC  = 8,
  parameter int         MIN_WIN     = 4,
  parameter logic [4:0] DEFAULT_TAP = 5'd3
) (
  input  logic       byte_clock,
  input  logic       reset_n,
  input  logic       cal_start,
  input  logic [7:0] deser_out,
  input  logic       deser_valid,
  output logic       dly_ld,
  output logic [4:0] dly_cntvalue,
  output logic       cal_busy,
  output logic       cal_done,
  output logic       cal_fail,
  output logic [4:0] win_start,
  output logic [5:0] win_len
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETTLE, SAMPLE, EVAL, APPLY, DONE
  } state_t;

  localparam logic [15:0] SAMP_LAST   = 16'(SAMPLE_LEN - 1);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [5:0]  MIN_WIN_L   = 6'(MIN_WIN);

  state_t      state_q;
  state_t      state_d;
  logic [4:0]  tap_q;
  logic [7:0]  settle_q;
  logic [15:0] samp_q;
  logic [15:0] mis_q;
  logic [4:0]  run_start_q;
  logic [5:0]  run_len_q;
  logic [4:0]  best_start_q;
  logic [5:0]  best_len_q;
  logic [4:0]  cnt_q;

  logic        byte_bad;
  logic        samp_done;
  logic        settle_done;
  logic        tap_good;
  logic [5:0]  run_len_nx;
  logic [4:0]  run_start_nx;
  logic        best_upd;
  logic        win_ok;
  logic [5:0]  half_len;
  logic [4:0]  apply_tap;

`ifdef CSI_RX_DLY_CAL_ROTATE_EN
  logic [2:0] rot_q;
  logic [2:0] rot_sel;
  logic       rot_hit;

  function automatic logic [7:0] rotl(input logic [2:0] r);
    logic [15:0] d;
    d = {PATTERN, PATTERN} >> (4'd8 - {1'b0, r});
    return d[7:0];
  endfunction

  // Descending scan so the lowest matching rotation wins.
  always_comb begin
    rot_hit = 1'b0;
    rot_sel = 3'd0;
    for (int r = 7; r >= 0; r--) begin
      if (deser_out == rotl(3'(r))) begin
        rot_hit = 1'b1;
        rot_sel = 3'(r);
      end
    end
  end

  always_comb begin
    byte_bad = 1'b0;
    if (samp_q == 16'd0) byte_bad = !rot_hit;
    else                 byte_bad = deser_out != rotl(rot_q);
  end

  always_ff @(posedge byte_clock or negedge reset_n) begin
    if (!reset_n) begin
      rot_q <= 3'd0;
    end else if (state_q == SAMPLE && deser_valid
                 && samp_q == 16'd0) begin
      rot_q <= rot_sel;
    end
  end
`else
  always_comb begin
    byte_bad = deser_out != PATTERN;
  end
`endif

  assign samp_done    = deser_valid && (samp_q == SAMP_LAST);
  assign settle_done  = settle_q == SETTLE_LAST;
  assign tap_good     = mis_q == 16'd0;
  assign run_len_nx   = tap_good ? run_len_q + 6'd1 : 6'd0;
  assign run_start_nx = (tap_good && run_len_q == 6'd0)
                        ? tap_q : run_start_q;
  assign best_upd     = run_len_nx > best_len_q;
  assign win_ok       = best_len_q >= MIN_WIN_L;
  assign half_len     = (best_len_q - 6'd1) >> 1;
  assign apply_tap    = win_ok ? best_start_q + half_len[4:0]
                               : DEFAULT_TAP;

  assign dly_ld = (state_q == LOAD) || (state_q == APPLY);

  // Present the new tap in the same cycle as LD.
  always_comb begin
    dly_cntvalue = cnt_q;
    unique case (1'b1)
      state_q == LOAD:  dly_cntvalue = tap_q;
      state_q == APPLY: dly_cntvalue = apply_tap;
      default: ;
    endcase
  end

  always_ff @(posedge byte_clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (cal_start) state_d = LOAD;
      LOAD:   state_d = SETTLE;
      SETTLE: if (settle_done) state_d = SAMPLE;
      SAMPLE: if (samp_done) state_d = EVAL;
      EVAL:   state_d = (tap_q == 5'd31) ? APPLY : LOAD;
      APPLY:  state_d = DONE;
      DONE:   if (cal_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge byte_clock or negedge reset_n) begin
    if (!reset_n) begin
      tap_q        <= 5'd0;
      settle_q     <= 8'd0;
      samp_q       <= 16'd0;
      mis_q        <= 16'd0;
      run_start_q  <= 5'd0;
      run_len_q    <= 6'd0;
      best_start_q <= 5'd0;
      best_len_q   <= 6'd0;
      cnt_q        <= DEFAULT_TAP;
      cal_busy     <= 1'b0;
      cal_done     <= 1'b0;
      cal_fail     <= 1'b0;
      win_start    <= 5'd0;
      win_len      <= 6'd0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (cal_start) begin
            tap_q        <= 5'd0;
            settle_q     <= 8'd0;
            samp_q       <= 16'd0;
            mis_q        <= 16'd0;
            run_start_q  <= 5'd0;
            run_len_q    <= 6'd0;
            best_start_q <= 5'd0;
            best_len_q   <= 6'd0;
            cal_busy     <= 1'b1;
            cal_done     <= 1'b0;
            cal_fail     <= 1'b0;
          end
        end
        LOAD: begin
          cnt_q    <= tap_q;
          settle_q <= 8'd0;
        end
        SETTLE: begin
          settle_q <= settle_q + 8'd1;
        end
        SAMPLE: begin
          if (deser_valid) begin
            samp_q <= samp_q + 16'd1;
            if (byte_bad && mis_q != 16'hFFFF)
              mis_q <= mis_q + 16'd1;
          end
        end
        EVAL: begin
          run_len_q   <= run_len_nx;
          run_start_q <= run_start_nx;
          if (best_upd) begin
            best_start_q <= run_start_nx;
            best_len_q   <= run_len_nx;
          end
          if (tap_q != 5'd31) begin
            tap_q  <= tap_q + 5'd1;
            samp_q <= 16'd0;
            mis_q  <= 16'd0;
          end
        end
        APPLY: begin
          cnt_q     <= apply_tap;
          cal_fail  <= !win_ok;
          win_start <= best_start_q;
          win_len   <= best_len_q;
          cal_busy  <= 1'b0;
          cal_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
